// File: rtl/regfile_wb_controller_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Grant encoding and write-port bundle used by the top and arbiter.
package regfile_wb_controller_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wb_controller_arb.sv
// Two-way writeback arbiter, round-robin or fixed LSU-first.
// Holds the last winner; grants depend only on valids and that flop.
module wb_rr_arbiter
  import regfile_wb_controller_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_gnt,
  output logic lsu_gnt
);

  gnt_e last_q;
  logic tie_lsu;

  assign tie_lsu = (ARB_MODE == 0) || (last_q == GNT_ALU);

  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    priority case (1'b1)
      rst: ;
      alu_valid && lsu_valid: begin
        lsu_gnt = tie_lsu;
        alu_gnt = !tie_lsu;
      end
      alu_valid: alu_gnt = 1'b1;
      lsu_valid: lsu_gnt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_LSU;
    end else if (alu_gnt) begin
      last_q <= GNT_ALU;
    end else if (lsu_gnt) begin
      last_q <= GNT_LSU;
    end
  end

endmodule

// File: rtl/regfile_wb_controller.sv
// Scoreboard of pending destination registers plus an arbitrated,
// registered drive of the register-file write port.
module regfile_wb_controller
  import regfile_wb_controller_pkg::*;
#(
  parameter int ARB_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  input  logic                  alu_wb_valid,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]       alu_wb_data,
  output logic                  alu_wb_ready,
  input  logic                  lsu_wb_valid,
  input  logic [REG_ADDR_W-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]       lsu_wb_data,
  output logic                  lsu_wb_ready,
  output logic                  rf_write_en,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data
);

  localparam logic [NUM_REGS-1:0] X0_MASK =
    {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  rf_wr_t              wr_q;
  rf_wr_t              wr_d;
  logic                alu_gnt;
  logic                lsu_gnt;

  wb_rr_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_wb_valid),
    .lsu_valid (lsu_wb_valid),
    .alu_gnt   (alu_gnt),
    .lsu_gnt   (lsu_gnt)
  );

  assign issue_ready  = !rst && !busy_q[issue_rd];
  assign rs1_busy     = busy_q[rs1_addr];
  assign rs2_busy     = busy_q[rs2_addr];
  assign alu_wb_ready = alu_gnt;
  assign lsu_wb_ready = lsu_gnt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (wr_q.en) begin
      clr_vec[wr_q.addr] = 1'b1;
    end
    // Clear wins over set; x0 can never be pending.
    busy_d = (busy_q | set_vec) & ~clr_vec & X0_MASK;
  end

  always_comb begin
    wr_d    = wr_q;
    wr_d.en = 1'b0;
    if (alu_gnt) begin
      wr_d.en   = (alu_wb_rd != '0);
      wr_d.addr = alu_wb_rd;
      wr_d.data = alu_wb_data;
    end else if (lsu_gnt) begin
      wr_d.en   = (lsu_wb_rd != '0);
      wr_d.addr = lsu_wb_rd;
      wr_d.data = lsu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
    end
  end

  assign rf_write_en   = wr_q.en;
  assign rf_write_addr = wr_q.addr;
  assign rf_write_data = wr_q.data;

  a_no_set_clr: assert property (
    @(posedge clk) disable iff (rst)
    !(|(set_vec & clr_vec & X0_MASK)));

  a_one_gnt: assert property (
    @(posedge clk) !(alu_gnt && lsu_gnt));

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller with a per-cycle
// reference model and literal spot checks.
module tb_regfile_wb_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        alu_wb_valid, lsu_wb_valid;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        alu_wb_ready, lsu_wb_ready;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;

  logic        f_alu_valid, f_lsu_valid;
  logic [4:0]  f_alu_rd, f_lsu_rd;
  logic [31:0] f_alu_data, f_lsu_data;
  logic        f_alu_ready, f_lsu_ready;
  logic        f_issue_ready, f_rs1_busy, f_rs2_busy;
  logic        f_en;
  logic [4:0]  f_addr;
  logic [31:0] f_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_wb_controller #(.ARB_MODE(1)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd),
    .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data)
  );

  regfile_wb_controller #(.ARB_MODE(0)) dut_fx (
    .clk(clk), .rst(rst),
    .issue_valid(1'b0), .issue_rd(5'd0),
    .issue_ready(f_issue_ready),
    .rs1_addr(5'd0), .rs2_addr(5'd0),
    .rs1_busy(f_rs1_busy), .rs2_busy(f_rs2_busy),
    .alu_wb_valid(f_alu_valid), .alu_wb_rd(f_alu_rd),
    .alu_wb_data(f_alu_data), .alu_wb_ready(f_alu_ready),
    .lsu_wb_valid(f_lsu_valid), .lsu_wb_rd(f_lsu_rd),
    .lsu_wb_data(f_lsu_data), .lsu_wb_ready(f_lsu_ready),
    .rf_write_en(f_en), .rf_write_addr(f_addr),
    .rf_write_data(f_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: set of pending registers, last tie winner,
  // and the write that is currently on the register-file port.
  bit [31:0] m_busy;
  bit        m_last_lsu;
  bit        m_en;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit        m_live = 1'b0;
  bit [1:0]  m_g;
  bit        m_rdy;

  function automatic bit [1:0] m_grant();
    if (rst) return 2'b00;
    if (alu_wb_valid && lsu_wb_valid)
      return m_last_lsu ? 2'b01 : 2'b10;
    if (alu_wb_valid) return 2'b01;
    if (lsu_wb_valid) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    m_g   = m_grant();
    m_rdy = !rst && !m_busy[issue_rd];
    if (rst) begin
      m_busy     = '0;
      m_last_lsu = 1'b1;
      m_en       = 1'b0;
      m_live     = 1'b1;
    end else begin
      if (m_en) m_busy[m_addr] = 1'b0;
      if (issue_valid && m_rdy && issue_rd != 0)
        m_busy[issue_rd] = 1'b1;
      m_en = 1'b0;
      if (m_g[0]) begin
        m_last_lsu = 1'b0;
        m_en   = (alu_wb_rd != 0);
        m_addr = alu_wb_rd;
        m_data = alu_wb_data;
      end else if (m_g[1]) begin
        m_last_lsu = 1'b1;
        m_en   = (lsu_wb_rd != 0);
        m_addr = lsu_wb_rd;
        m_data = lsu_wb_data;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_issue_ready", issue_ready,
          !rst && !m_busy[issue_rd]);
      chk("m_rs1_busy", rs1_busy, m_busy[rs1_addr]);
      chk("m_rs2_busy", rs2_busy, m_busy[rs2_addr]);
      chk("m_alu_ready", alu_wb_ready, m_grant() == 2'b01);
      chk("m_lsu_ready", lsu_wb_ready, m_grant() == 2'b10);
      chk("m_wr_en", rf_write_en, m_en);
      if (m_en) begin
        chk("m_wr_addr", rf_write_addr, m_addr);
        chk("m_wr_data", rf_write_data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 0; issue_rd  = 0;
    rs1_addr     = 0; rs2_addr  = 0;
    alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    f_alu_valid  = 0; f_alu_rd  = 0; f_alu_data  = 0;
    f_lsu_valid  = 0; f_lsu_rd  = 0; f_lsu_data  = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    tick();
    alu_wb_valid = 1; alu_wb_rd = 4; issue_rd = 1;
    #1;
    chk("rst_alu_ready", alu_wb_ready, 0);
    chk("rst_issue_ready", issue_ready, 0);
    tick();
    rst = 0;
    idle();
    #1;
    chk("rst_wr_en", rf_write_en, 0);
    chk("rst_issue_ready_lo", issue_ready, 1);

    // Reserve x5, read it busy, write it back.
    issue_valid = 1; issue_rd = 5;
    #1 chk("raw_issue_ready", issue_ready, 1);
    tick();
    idle();
    rs1_addr = 5;
    alu_wb_valid = 1; alu_wb_rd = 5; alu_wb_data = 32'hDEADBEEF;
    #1;
    chk("raw_rs1_busy", rs1_busy, 1);
    chk("raw_alu_ready", alu_wb_ready, 1);
    tick();
    idle();
    rs1_addr = 5;
    #1;
    chk("raw_wr_en", rf_write_en, 1);
    chk("raw_wr_addr", rf_write_addr, 5);
    chk("raw_wr_data", rf_write_data, 32'hDEADBEEF);
    chk("raw_rs1_still", rs1_busy, 1);
    tick();
    rs1_addr = 5;
    #1 chk("raw_rs1_clear", rs1_busy, 0);

    // WAW stall on x7.
    idle();
    issue_valid = 1; issue_rd = 7;
    tick();
    alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'h77;
    #1;
    chk("waw_stall0", issue_ready, 0);
    chk("waw_alu_ready", alu_wb_ready, 1);
    tick();
    alu_wb_valid = 0;
    #1;
    chk("waw_wr_addr", rf_write_addr, 7);
    chk("waw_stall1", issue_ready, 0);
    tick();
    #1 chk("waw_ready", issue_ready, 1);
    tick();
    idle();
    alu_wb_valid = 1; alu_wb_rd = 7; alu_wb_data = 32'h70;
    tick();
    idle();
    tick();
    rs2_addr = 7;
    #1 chk("waw_rs2_clear", rs2_busy, 0);

    // x0 reservation and write are no-ops on the port.
    idle();
    issue_valid = 1; issue_rd = 0; rs1_addr = 0;
    alu_wb_valid = 1; alu_wb_rd = 0; alu_wb_data = 32'h1;
    #1;
    chk("x0_issue_ready", issue_ready, 1);
    chk("x0_rs1_busy", rs1_busy, 0);
    chk("x0_alu_ready", alu_wb_ready, 1);
    tick();
    idle();
    #1 chk("x0_wr_en", rf_write_en, 0);

    // Reset in flight with x3/x9 pending and an LSU write.
    issue_valid = 1; issue_rd = 3;
    tick();
    issue_rd = 9;
    tick();
    idle();
    lsu_wb_valid = 1; lsu_wb_rd = 3; lsu_wb_data = 32'h33;
    tick();
    idle();
    rst = 1;
    lsu_wb_valid = 1; lsu_wb_rd = 9; lsu_wb_data = 32'h99;
    #1 chk("mid_rst_lsu_ready", lsu_wb_ready, 0);
    tick();
    rst = 0;
    idle();
    rs1_addr = 3; rs2_addr = 9;
    #1;
    chk("mid_rst_wr_en", rf_write_en, 0);
    chk("mid_rst_rs1", rs1_busy, 0);
    chk("mid_rst_rs2", rs2_busy, 0);

    // Ties: round-robin starts with ALU; fixed always LSU.
    idle();
    for (int i = 0; i < 4; i++) begin
      alu_wb_valid = 1; alu_wb_rd = 20; alu_wb_data = 32'hA0 + i;
      lsu_wb_valid = 1; lsu_wb_rd = 21; lsu_wb_data = 32'hB0 + i;
      f_alu_valid = 1; f_alu_rd = 20; f_alu_data = 32'hC0 + i;
      f_lsu_valid = 1; f_lsu_rd = 21; f_lsu_data = 32'hD0 + i;
      #1;
      chk("rr_alu_ready", alu_wb_ready, (i % 2) == 0);
      chk("rr_lsu_ready", lsu_wb_ready, (i % 2) == 1);
      chk("fx_alu_ready", f_alu_ready, 0);
      chk("fx_lsu_ready", f_lsu_ready, 1);
      if (i > 0) begin
        chk("rr_wr_addr", rf_write_addr, (i % 2) ? 20 : 21);
        chk("fx_wr_addr", f_addr, 21);
        chk("fx_wr_data", f_data, 32'hD0 + i - 1);
      end
      tick();
    end
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_wb_controller.md
REGFILE_WB_CONTROLLER -- requirements
Module: regfile_wb_controller

Interface
REQ-001 SHALL have parameter ARB_MODE, default 1, selecting the arbiter: 1 = round-robin, 0 = fixed priority with LSU over ALU.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port issue_valid  in  1  the decoder requests to reserve a destination register.
REQ-005 SHALL have port issue_rd  in  5  destination register to reserve.
REQ-006 SHALL have port issue_ready  out  1  the reservation is accepted this cycle.
REQ-007 SHALL have ports rs1_addr, rs2_addr  in  5 each  source registers being read.
REQ-008 SHALL have ports rs1_busy, rs2_busy  out  1 each  the source has a pending write (RAW hazard).
REQ-009 SHALL have ports alu_wb_valid, alu_wb_rd, alu_wb_data  in  1/5/32  ALU writeback request.
REQ-010 SHALL have port alu_wb_ready  out  1  the ALU request is granted this cycle.
REQ-011 SHALL have ports lsu_wb_valid, lsu_wb_rd, lsu_wb_data  in  1/5/32  load-unit writeback request.
REQ-012 SHALL have port lsu_wb_ready  out  1  the LSU request is granted this cycle.
REQ-013 SHALL have ports rf_write_en, rf_write_addr, rf_write_data  out  1/5/32  registered drive of the register-file write port.

Function
REQ-014 SHALL keep a 32-bit busy vector; bit 0 SHALL read as 0 at all times.
REQ-015 SHALL drive issue_ready = !busy[issue_rd] combinationally; a WAW reservation stalls until the register is no longer busy.
REQ-016 SHALL set busy[issue_rd] at the clock edge where issue_valid && issue_ready, unless issue_rd = 0.
REQ-017 SHALL drive rsN_busy = busy[rsN_addr] combinationally; rsN_addr = 0 SHALL give 0.
REQ-018 SHALL grant at most one writeback per cycle; ready SHALL depend only on the valids and the arbiter state, never on the data.
REQ-019 SHALL use an arbiter that, in round-robin mode with both requesters valid, grants the requester not granted last; the last_grant flop SHALL update only on a grant.
REQ-020 SHALL use an arbiter that, in fixed mode with both requesters valid, always grants the LSU.
REQ-021 SHALL grant a single valid requester in the same cycle, in either mode.
REQ-022 SHALL, on a grant, register rf_write_en=1, rf_write_addr=rd and rf_write_data=data at the edge, giving 1-cycle latency; with no grant it SHALL register rf_write_en=0.
REQ-023 SHALL register rf_write_en=0 for a granted write with rd = 0, but still complete the handshake.
REQ-024 SHALL clear busy[rf_write_addr] at the edge where rf_write_en=1, which is the same edge the register file commits; rsN_busy therefore drops only after the data is readable.
REQ-025 SHALL give the clear priority over the set if both target the same register on one edge; by REQ-015 this cannot occur with legal stimulus, so an assertion SHALL flag it.
REQ-026 SHALL NOT stall requesters and SHALL need no skid buffer: the output stage accepts one write every cycle.

Reset
REQ-027 SHALL, with rst high at an edge, clear busy, rf_write_en, rf_write_addr and rf_write_data to 0, and set last_grant to LSU so that the ALU wins the first round-robin tie.
REQ-028 SHALL drop in-flight grants and pending reservations when reset arrives mid-operation, with no write issued after the reset edge.
REQ-029 SHALL hold issue_ready and the wb_ready outputs at 0 while rst is high.

Structure
REQ-030 SHALL take the constants REG_ADDR_W=5, XLEN=32 and the grant encoding (GNT_ALU, GNT_LSU) from the shared core package.
REQ-031 SHALL be built from one sub-module, wb_rr_arbiter: a 2-way arbiter with ARB_MODE that holds last_grant.
REQ-032 SHALL keep the busy vector and output flops in the top level; the register file itself SHALL stay outside this block.

Verification
REQ-033 SHALL cover: issue rd=5; next cycle rs1_addr=5 -> rs1_busy=1; ALU wb rd=5 data=0xDEADBEEF -> alu_wb_ready=1, next cycle rf_write_en=1, addr=5, data=0xDEADBEEF; the cycle after, rs1_busy=0.
REQ-034 SHALL cover: ARB_MODE=1, both requesters valid for 4 cycles -> grants ALU, LSU, ALU, LSU; with ARB_MODE=0 -> LSU in all 4 cycles.
REQ-035 SHALL cover: issue rd=7 while busy[7]=1 -> issue_ready=0 until the cycle after rf_write_en with addr=7, then 1.
REQ-036 SHALL cover: issue rd=0 and ALU wb rd=0 data=0x1 -> rs1_busy(rs1=0)=0, alu_wb_ready=1, rf_write_en stays 0.
REQ-037 SHALL cover: busy regs 3 and 9 with an LSU grant pending, then rst high for 1 cycle -> rf_write_en=0 the next cycle, rs1_busy(3)=0, rs2_busy(9)=0, first tie grants ALU.
